// File: rtl/dadda_mac_acc_if.sv
// dadda_mac_acc_if: operand input and dot-product output handshakes of the MAC
interface dadda_mac_acc_if #(parameter int ACC_W = 19);
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       a;
  logic [7:0]       b;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_acc;
  logic             out_ovf;
  modport master (output in_valid, a, b, out_ready, input in_ready, out_valid, out_acc, out_ovf);
  modport slave (input in_valid, a, b, out_ready, output in_ready, out_valid, out_acc, out_ovf);
endinterface

// File: rtl/dadda_mac_acc.sv
// dadda_mac_acc: streaming multiply-accumulate of N_TERMS products from an 8x8 Dadda multiplier
module dadda_8 (
  input  logic [7:0]  i_a,
  input  logic [7:0]  i_b,
  output logic [15:0] o_p
);
  logic [7:0][15:0] w_pp;
  logic [5:0][15:0] w_s1;
  logic [3:0][15:0] w_s2;
  logic [2:0][15:0] w_s3;
  logic [1:0][15:0] w_s4;
  function automatic logic [31:0] csa(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
    return {(x & y | x & z | y & z) << 1, x ^ y ^ z};
  endfunction
  // Partial products reduced through heights 8-6-4-3-2 with 3:2 compressors, carry word above sum word
  always_comb begin
    for (int i = 0; i < 8; i++) w_pp[i] = {8'h00, i_a & {8{i_b[i]}}} << i;
    w_s1[1:0] = csa(w_pp[0], w_pp[1], w_pp[2]);
    w_s1[3:2] = csa(w_pp[3], w_pp[4], w_pp[5]);
    w_s1[5:4] = w_pp[7:6];
    w_s2[1:0] = csa(w_s1[0], w_s1[1], w_s1[2]);
    w_s2[3:2] = csa(w_s1[3], w_s1[4], w_s1[5]);
    w_s3[1:0] = csa(w_s2[0], w_s2[1], w_s2[2]);
    w_s3[2]   = w_s2[3];
    w_s4      = csa(w_s3[0], w_s3[1], w_s3[2]);
  end
  assign o_p = w_s4[0] + w_s4[1];
endmodule

module dadda_mac_acc #(
  parameter int N_TERMS = 8,
  parameter int ACC_W   = 19
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  dadda_mac_acc_if.slave  bus
);
  typedef enum logic {ACCUM, DONE} state_t;
  localparam logic [7:0] N = 8'(N_TERMS);
  state_t           r_state, w_state_nxt;
  logic [7:0]       r_a, r_b, r_acc_cnt, r_sum_cnt, w_acc_cnt_nxt;
  logic             r_v1, r_v2, r_in_ready, r_ovf;
  logic [15:0]      r_p, w_prod;
  logic [ACC_W-1:0] r_acc;
  logic [ACC_W:0]   w_sum;
  logic             w_accept, w_clear;

  dadda_8 u_mul (.i_a(r_a), .i_b(r_b), .o_p(w_prod));

  // Handshake decode and next state: DONE once the last product lands, back to ACCUM on consume
  always_comb begin
    w_accept      = bus.in_valid & r_in_ready;
    w_clear       = rst | flush | (r_state == DONE & bus.out_ready);
    w_sum         = {1'b0, r_acc} + {{(ACC_W - 15){1'b0}}, r_p};
    w_acc_cnt_nxt = w_clear ? 8'd0 : r_acc_cnt + {7'd0, w_accept};
    w_state_nxt   = r_state == ACCUM ? ((r_v2 && r_sum_cnt + 8'd1 == N) ? DONE : ACCUM)
                                     : (bus.out_ready ? ACCUM : DONE);
  end

  // State register; rst and flush both abort to ACCUM
  always_ff @(posedge clk) r_state <= (rst | flush) ? ACCUM : w_state_nxt;

  // in_ready registered from next state and next count so it has no path from in_valid/out_ready
  always_ff @(posedge clk) r_in_ready <= rst | flush | (w_state_nxt == ACCUM && w_acc_cnt_nxt < N);

  // Operand and product stages; contents are don't-care whenever their valid bit is low
  always_ff @(posedge clk) begin
    if (w_accept) {r_a, r_b} <= {bus.a, bus.b};
    r_p <= w_prod;
  end

  // Valid pipeline, counters and wrapping accumulator with sticky carry-out
  always_ff @(posedge clk) begin
    if (w_clear) begin
      {r_v1, r_v2, r_ovf} <= '0;
      r_acc_cnt <= '0;
      r_sum_cnt <= '0;
      r_acc     <= '0;
    end else begin
      r_v1      <= w_accept;
      r_v2      <= r_v1;
      r_acc_cnt <= w_acc_cnt_nxt;
      if (r_v2) begin
        r_acc     <= w_sum[ACC_W-1:0];
        r_ovf     <= r_ovf | w_sum[ACC_W];
        r_sum_cnt <= r_sum_cnt + 8'd1;
      end
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_state == DONE;
  assign bus.out_acc   = r_acc;
  assign bus.out_ovf   = r_ovf;
endmodule

// File: tb/tb_dadda_mac_acc.sv
// tb_dadda_mac_acc: randomized scoreboard bench over three parameterizations of the MAC
module tb_dadda_mac_acc;
  logic        clk = 0, rst = 1, flush = 0, in_valid = 0, out_ready = 1, rand_or = 0;
  logic [7:0]  a = 0, b = 0;
  int          sel = 0, cyc = 0, total = 0, bad = 0, n_res = 0, hs_cyc = 0;
  longint      last_acc = 0, m_sum = 0;
  logic        last_ovf = 0;
  int          m_cnt = 0;
  logic [32:0] q[$];
  int          nt_tab[3] = '{8, 4, 1};
  int          aw_tab[3] = '{19, 16, 19};
  logic        s_ir, s_ov, s_ovf;
  logic [31:0] s_acc;

  dadda_mac_acc_if #(.ACC_W(19)) if0 ();
  dadda_mac_acc_if #(.ACC_W(16)) if1 ();
  dadda_mac_acc_if #(.ACC_W(19)) if2 ();

  assign if0.in_valid = in_valid && sel == 0;
  assign if1.in_valid = in_valid && sel == 1;
  assign if2.in_valid = in_valid && sel == 2;
  assign if0.out_ready = out_ready && sel == 0;
  assign if1.out_ready = out_ready && sel == 1;
  assign if2.out_ready = out_ready && sel == 2;
  assign if0.a = a;
  assign if1.a = a;
  assign if2.a = a;
  assign if0.b = b;
  assign if1.b = b;
  assign if2.b = b;

  dadda_mac_acc #(.N_TERMS(8), .ACC_W(19)) u0 (.clk(clk), .rst(rst), .flush(flush), .bus(if0));
  dadda_mac_acc #(.N_TERMS(4), .ACC_W(16)) u1 (.clk(clk), .rst(rst), .flush(flush), .bus(if1));
  dadda_mac_acc #(.N_TERMS(1), .ACC_W(19)) u2 (.clk(clk), .rst(rst), .flush(flush), .bus(if2));

  always_comb begin
    s_ir  = sel == 0 ? if0.in_ready : sel == 1 ? if1.in_ready : if2.in_ready;
    s_ov  = sel == 0 ? if0.out_valid : sel == 1 ? if1.out_valid : if2.out_valid;
    s_ovf = sel == 0 ? if0.out_ovf : sel == 1 ? if1.out_ovf : if2.out_ovf;
    s_acc = sel == 0 ? 32'(if0.out_acc) : sel == 1 ? 32'(if1.out_acc) : 32'(if2.out_acc);
  end

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  // Reference model: each accepted pair adds a*b to an unbounded sum; every N-th term closes a result
  always @(negedge clk) begin
    longint lim;
    lim = 64'd1 << aw_tab[sel];
    if (rst || flush) begin
      m_sum = 0;
      m_cnt = 0;
      q.delete();
    end else if (in_valid && s_ir) begin
      m_sum += longint'(a) * longint'(b);
      m_cnt++;
      if (m_cnt == nt_tab[sel]) begin
        q.push_back({m_sum >= lim, 32'(m_sum % lim)});
        m_sum = 0;
        m_cnt = 0;
      end
    end
  end

  // Monitor: every output handshake is checked against the oldest expected result
  always @(negedge clk) begin
    logic [32:0] e;
    if (!rst && !flush && s_ov && out_ready) begin
      n_res++;
      hs_cyc = cyc + 1;
      last_acc = s_acc;
      last_ovf = s_ovf;
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_result got=%0d want=none", s_acc);
      end else begin
        e = q.pop_front();
        chk("result_acc", s_acc, e[31:0]);
        chk("result_ovf", s_ovf, e[32]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_or) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input logic [7:0] x, input logic [7:0] y);
    int n = 0;
    logic ok;
    in_valid = 1;
    a = x;
    b = y;
    do begin
      ok = s_ir;
      tick();
      n++;
    end while (!ok && n < 300);
    in_valid = 0;
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL send_timeout got=stalled want=accepted");
    end
  endtask

  task automatic bubble();
    repeat ($urandom_range(0, 2)) tick();
  endtask

  task automatic drain();
    int n = 0;
    rand_or = 0;
    out_ready = 1;
    while ((q.size() != 0 || s_ov) && n < 300) begin
      tick();
      n++;
    end
    if (n >= 300) begin
      total++;
      bad++;
      $display("FAIL drain_timeout got=pending want=idle");
    end
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!s_ov && n < 100) begin
      tick();
      n++;
    end
    if (!s_ov) begin
      total++;
      bad++;
      $display("FAIL valid_timeout got=0 want=1");
    end
  endtask

  task automatic pulse(input logic r, input logic f);
    rst = r;
    flush = f;
    tick();
    rst = 0;
    flush = 0;
  endtask

  initial begin
    int first, low, r0;
    logic [31:0] snap;
    repeat (2) tick();
    rst = 0;
    chk("rst_ready0", if0.in_ready, 1);
    chk("rst_valid0", if0.out_valid, 0);
    chk("rst_acc0", if0.out_acc, 0);
    chk("rst_ovf0", if0.out_ovf, 0);
    chk("rst_ready1", if1.in_ready, 1);
    chk("rst_valid1", if1.out_valid, 0);
    chk("rst_acc1", if1.out_acc, 0);
    chk("rst_ovf1", if1.out_ovf, 0);
    chk("rst_ready2", if2.in_ready, 1);
    chk("rst_valid2", if2.out_valid, 0);
    chk("rst_acc2", if2.out_acc, 0);
    chk("rst_ovf2", if2.out_ovf, 0);

    in_valid = 1;
    a = 255;
    b = 255;
    first = cyc + 1;
    repeat (8) tick();
    in_valid = 0;
    low = 0;
    for (int i = 0; i < 8; i++) begin
      if (!s_ir) low++;
      tick();
    end
    chk("burst_latency", hs_cyc - first, 10);
    chk("burst_ready_low", low, 3);
    chk("burst_acc", last_acc, 520200);
    chk("burst_ovf", last_ovf, 0);

    r0 = n_res;
    for (int k = 1; k <= 8; k++) begin
      send(8'(k), 8'd2);
      bubble();
    end
    drain();
    chk("bubble_results", n_res - r0, 1);
    chk("bubble_acc", last_acc, 72);

    out_ready = 0;
    repeat (8) send(8'($urandom), 8'($urandom));
    wait_valid();
    snap = s_acc;
    in_valid = 1;
    a = 77;
    b = 77;
    for (int i = 0; i < 5; i++) begin
      chk("bp_acc_stable", s_acc, snap);
      chk("bp_valid", s_ov, 1);
      chk("bp_ready", s_ir, 0);
      tick();
    end
    in_valid = 0;
    drain();
    repeat (8) send(8'd1, 8'd1);
    drain();
    chk("bp_next_acc", last_acc, 8);

    for (int f = 0; f < 3; f++) begin
      repeat (3) send(8'd10, 8'd10);
      pulse(f != 1, f != 0);
      repeat (8) send(8'd1, 8'd1);
      drain();
      chk("abort_acc", last_acc, 8);
    end

    out_ready = 0;
    repeat (8) send(8'($urandom), 8'($urandom));
    wait_valid();
    pulse(0, 1);
    chk("flush_done_valid", s_ov, 0);
    chk("flush_done_ready", s_ir, 1);
    out_ready = 1;
    r0 = n_res;
    repeat (3) tick();
    chk("flush_done_dropped", n_res - r0, 0);

    sel = 1;
    repeat (4) send(8'd255, 8'd255);
    drain();
    chk("n4_wrap_acc", last_acc, 63492);
    chk("n4_wrap_ovf", last_ovf, 1);
    repeat (4) send(8'd1, 8'd1);
    drain();
    chk("n4_next_acc", last_acc, 4);
    chk("n4_next_ovf", last_ovf, 0);

    sel = 2;
    send(8'd0, 8'd200);
    drain();
    chk("n1_zero", last_acc, 0);
    send(8'd200, 8'd3);
    drain();
    chk("n1_600", last_acc, 600);

    for (int s = 0; s < 3; s++) begin
      sel = s;
      rand_or = 1;
      repeat (6 * nt_tab[s]) begin
        send(8'($urandom), 8'($urandom));
        bubble();
      end
      drain();
    end
    chk("queue_empty", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/dadda_mac_acc.md
# dadda_mac_acc

Pipelined multiply-accumulate stage sitting directly downstream of the 8x8 Dadda multiplier (`dadda_8`). It accepts operand pairs over a valid/ready handshake and registers them into an internal `dadda_8` instance. It then registers the 16-bit product and accumulates exactly N_TERMS products into a dot-product result, which it presents on a valid/ready output port. It is the first clocked block in the multiplier datapath and turns the purely combinational multiplier into a streaming MAC.

## Interface
- N_TERMS, default 8: products summed per result; legal range 1..255.
- ACC_W, default 19: accumulator width; legal range 16..32. The default holds 8 × 255 × 255 = 520200 exactly.
- clk  input  1  sole clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  synchronous abort of the current dot product; same effect as rst, lower priority than rst.
- in_valid  input  1  operand pair present.
- in_ready  output  1  block can accept a pair this cycle.
- a  input  8  unsigned multiplicand.
- b  input  8  unsigned multiplier.
- out_valid  output  1  result present.
- out_ready  input  1  consumer takes the result.
- out_acc  output  ACC_W  accumulated sum, unsigned.
- out_ovf  output  1  sticky: a carry out of bit ACC_W-1 occurred during this result.

## Operation
- Datapath stages:
  - S1 operand regs a_q/b_q plus v1.
  - The `dadda_8` instance computes a_q*b_q combinationally.
  - S2 product reg p_q[15:0] plus v2.
  - S3 accumulator acc[ACC_W-1:0].
- Counters:
  - acc_cnt: pairs accepted, 0..N_TERMS.
  - sum_cnt: products added, 0..N_TERMS.
- FSM states:
  - ACCUM:
    - in_ready = (acc_cnt < N_TERMS).
    - Handshake in_valid & in_ready loads S1 and increments acc_cnt.
    - v2 = v1 each edge. When v2 = 1: acc <= acc + zero-extended p_q, and sum_cnt increments.
    - When the add makes sum_cnt = N_TERMS: go to DONE.
  - DONE:
    - out_valid = 1, in_ready = 0.
    - out_acc and out_ovf are held stable.
    - out_valid & out_ready: clear acc, out_ovf, both counters, v1 and v2; go to ACCUM.
- Arithmetic:
  - The sum wraps modulo 2^ACC_W.
  - out_ovf sets on any carry out of the ACC_W-bit add, and stays set until the result is consumed or the block is reset.
- in_valid while in_ready = 0: no effect; a/b are ignored.
- in_valid gaps (bubbles) are legal; the pipeline simply carries v1 = 0.
- rst or flush:
  - State ACCUM.
  - acc, counters, v1, v2 and out_ovf all cleared.
  - In-flight terms are discarded.
  - a_q/b_q/p_q may hold stale data but are ignored.

## Timing
- Reset values:
  - in_ready = 1.
  - out_valid = 0, out_acc = 0, out_ovf = 0.
- in_ready is a registered decode of state and acc_cnt. It has no combinational path from in_valid or out_ready.
- Latency: a pair accepted at edge E reaches the accumulator at edge E+2.
  - If that pair is the N_TERMS-th term, out_valid is high in the cycle after E+2.
- Throughput: one pair per cycle. A back-to-back N_TERMS burst yields a result N_TERMS+2 edges after the first accept.
- Between results:
  - in_ready drops the cycle after the N_TERMS-th accept.
  - It stays 0 through drain and DONE.
  - It returns to 1 the cycle after the out_valid & out_ready edge.
  - Minimum gap per result is therefore 3 cycles plus output wait.
- out_valid held with out_ready = 0: out_acc, out_ovf and out_valid remain unchanged indefinitely.
- rst and flush asserted together: rst wins (identical effect).
- flush during DONE: the result is dropped; out_valid = 0 on the next cycle.

## Test plan
- Default params, 8 back-to-back pairs 255×255, out_ready = 1:
  - out_acc = 520200, out_ovf = 0.
  - out_valid rises exactly 10 edges after the first accept.
  - in_ready low for exactly 3 cycles.
- Default params, pairs (k, 2) for k = 1..8, with in_valid bubbles inserted randomly:
  - out_acc = 72.
  - out_valid is asserted once only.
  - No extra term is accepted beyond 8.
- Backpressure: out_ready held 0 for 5 cycles after out_valid:
  - out_acc stable, in_ready = 0, extra in_valid ignored.
  - On release, the next dot product starts from acc = 0.
- Mid-operation abort: accept 3 pairs of 10×10, pulse rst (repeat the test with flush), then accept 8 pairs of 1×1:
  - The result is 8, not 308.
- N_TERMS = 4, ACC_W = 16, four pairs 255×255:
  - out_acc = 63492 (260100 mod 65536), out_ovf = 1.
  - The following result of four pairs 1×1 gives out_acc = 4, out_ovf = 0.
- N_TERMS = 1:
  - Each accept yields a result.
  - Pair 0×200 gives out_acc = 0.
  - Pair 200×3 gives 600.
